// File: rtl/code_density_sequencer.sv
// ADC code-density acquisition: gates conversions, builds a saturating histogram in block RAM,
// then streams the bins out. Optional min/max tracking under `CODE_DENSITY_MINMAX_EN.
module code_density_sequencer #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned NS_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NS_WIDTH-1:0]  n_samples,
    input  logic                 abort,
    input  logic                 d_en,
    input  logic [WIDTH-1:0]     pdo,
    output logic                 acq_en,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [WIDTH-1:0]     hist_addr,
    output logic [CNT_WIDTH-1:0] hist_data,
    output logic                 hist_valid,
    input  logic                 hist_ready,
    output logic                 hist_last,
    output logic [WIDTH-1:0]     code_min,
    output logic [WIDTH-1:0]     code_max
);

    localparam int unsigned NBINS = 2 ** WIDTH;

    typedef enum logic [2:0] {StClear, StIdle, StAcquire, StDrain, StDump} state_e;

    state_e                 r_state, w_state_nxt;
    logic [WIDTH-1:0]       r_clr_addr;
    logic [NS_WIDTH-1:0]    r_n, r_cnt;
    logic                   r_overrun;
    logic [1:0]             r_ph;
    logic [WIDTH-1:0]       r_unit_addr;
    logic                   r_slot_vld;
    logic [WIDTH-1:0]       r_slot_addr;
    logic [CNT_WIDTH-1:0]   r_sum;
    logic [CNT_WIDTH-1:0]   r_rdata;
    logic [1:0]             r_dph;
    logic                   r_valid;
    logic [WIDTH-1:0]       r_haddr;
    logic                   r_done;
    logic [CNT_WIDTH-1:0]   r_mem [NBINS];

    logic                   w_start_acc, w_abort_acc, w_in_acq, w_accept, w_drop;
    logic                   w_last_sample, w_unit_free, w_fire, w_last_beat;
    logic                   w_we;
    logic [WIDTH-1:0]       w_waddr, w_raddr;
    logic [CNT_WIDTH-1:0]   w_wdata;

    assign w_start_acc   = (r_state == StIdle) && start;
    assign w_abort_acc   = abort && ((r_state == StAcquire) || (r_state == StDrain) ||
                                     (r_state == StDump));
    assign w_in_acq      = (r_state == StAcquire);
    // The slot is only ever full while the unit is busy, so a free slot means room.
    assign w_accept      = w_in_acq && d_en && !r_slot_vld;
    assign w_drop        = w_in_acq && d_en && r_slot_vld;
    assign w_last_sample = w_accept && ((r_cnt + NS_WIDTH'(1)) == r_n);
    assign w_unit_free   = (r_ph == 2'd0) || (r_ph == 2'd3);
    assign w_fire        = r_valid && hist_ready;
    assign w_last_beat   = w_fire && (r_haddr == '1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StClear:   if (r_clr_addr == '1) w_state_nxt = StIdle;
            StIdle:    if (start) w_state_nxt = (n_samples == '0) ? StDump : StAcquire;
            StAcquire: begin
                if (abort)              w_state_nxt = StClear;
                else if (w_last_sample) w_state_nxt = StDrain;
            end
            StDrain: begin
                if (abort)                                w_state_nxt = StClear;
                else if ((r_ph == 2'd0) && !r_slot_vld)   w_state_nxt = StDump;
            end
            StDump:    if (abort || w_last_beat) w_state_nxt = StClear;
            default:   w_state_nxt = StClear;
        endcase
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_unit_addr;
        w_wdata = r_sum;
        w_raddr = r_unit_addr;
        if (r_state == StClear) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = '0;
        end else if (r_ph == 2'd3) begin
            w_we = 1'b1;
        end
        // Read ahead on a handshake, otherwise re-read the held bin so data stays stable.
        if (r_state == StDump) begin
            w_raddr = w_fire ? (r_haddr + WIDTH'(1)) : r_haddr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rdata <= '0;
        else     r_rdata <= r_mem[w_raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StClear;
            r_clr_addr  <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_overrun   <= 1'b0;
            r_ph        <= 2'd0;
            r_unit_addr <= '0;
            r_slot_vld  <= 1'b0;
            r_slot_addr <= '0;
            r_sum       <= '0;
            r_dph       <= 2'd0;
            r_valid     <= 1'b0;
            r_haddr     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= (r_state == StDump) && !abort && w_last_beat;
            r_clr_addr <= (r_state == StClear) ? (r_clr_addr + WIDTH'(1)) : '0;

            if (w_start_acc) begin
                r_n       <= n_samples;
                r_cnt     <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (w_accept) r_cnt     <= r_cnt + NS_WIDTH'(1);
                if (w_drop)   r_overrun <= 1'b1;
            end

            // RMW phases: 1 read issue, 2 read data -> sat(x+1), 3 write back.
            if (w_abort_acc) begin
                r_ph       <= 2'd0;
                r_slot_vld <= 1'b0;
            end else if (w_unit_free) begin
                if (r_slot_vld) begin
                    r_unit_addr <= r_slot_addr;
                    r_ph        <= 2'd1;
                    r_slot_vld  <= 1'b0;
                end else if (w_accept) begin
                    r_unit_addr <= pdo;
                    r_ph        <= 2'd1;
                end else begin
                    r_ph <= 2'd0;
                end
            end else begin
                r_ph <= r_ph + 2'd1;
                if (w_accept) begin
                    r_slot_addr <= pdo;
                    r_slot_vld  <= 1'b1;
                end
            end
            if (r_ph == 2'd2) r_sum <= (r_rdata == '1) ? r_rdata : (r_rdata + CNT_WIDTH'(1));

            if ((r_state == StDump) && !abort) begin
                if (r_dph != 2'd2) begin
                    r_dph   <= r_dph + 2'd1;
                    r_valid <= (r_dph == 2'd1);
                end else if (w_fire) begin
                    if (r_haddr == '1) r_valid <= 1'b0;
                    else               r_haddr <= r_haddr + WIDTH'(1);
                end
            end else begin
                r_dph   <= 2'd0;
                r_valid <= 1'b0;
                r_haddr <= '0;
            end
        end
    end

`ifdef CODE_DENSITY_MINMAX_EN
    logic [WIDTH-1:0] r_min, r_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min <= '0;
            r_max <= '0;
        end else if (w_start_acc) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_accept) begin
            if (pdo < r_min) r_min <= pdo;
            if (pdo > r_max) r_max <= pdo;
        end
    end

    assign code_min = r_min;
    assign code_max = r_max;
`else
    assign code_min = '0;
    assign code_max = '0;
`endif

    assign acq_en     = (r_state == StAcquire);
    assign busy       = (r_state != StIdle);
    assign done       = r_done;
    assign overrun    = r_overrun;
    assign hist_addr  = r_haddr;
    assign hist_data  = r_rdata;
    assign hist_valid = r_valid;
    assign hist_last  = r_valid && (r_haddr == '1);

endmodule

// File: doc/code_density_sequencer.md
# code_density_sequencer

Acquisition controller for the ADC code-density (histogram) test. It gates conversions of the SPI receiver through `acq_en` and accepts a programmed number of samples from its `d_en`/`pdo` output. Each sample increments a saturating histogram bin in internal block RAM. On completion, the block streams the 2^WIDTH bins out over a valid/ready port toward the readout/UART path.

## Interface
Parameters:
- `WIDTH`, 10: ADC code width; histogram has 2^WIDTH bins.
- `CNT_WIDTH`, 32: bin counter width.
- `NS_WIDTH`, 32: sample-count width.

Ports:
- `clk`  in  1  system clock (PLL domain of the SPI receiver).
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  single-cycle run request.
- `n_samples`  in  NS_WIDTH  samples per run; latched when `start` is accepted.
- `abort`  in  1  cancel the current run.
- `d_en`  in  1  sample-valid pulse from the SPI receiver.
- `pdo`  in  WIDTH  sample code; valid only when `d_en` is high.
- `acq_en`  out  1  conversion enable to the SPI receiver.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a run completes.
- `overrun`  out  1  sticky flag: a sample was dropped; cleared on accepted `start`.
- `hist_addr`  out  WIDTH  bin index of the current beat.
- `hist_data`  out  CNT_WIDTH  bin count.
- `hist_valid`  out  1  beat valid.
- `hist_ready`  in  1  sink ready.
- `hist_last`  out  1  high on the beat with `hist_addr` = 2^WIDTH−1.
- `code_min`, `code_max`  out  WIDTH each  extreme codes of the run (see Configuration).

## Operation
- States:
  - CLEAR: write 0 to bins 0..2^WIDTH−1, one per cycle, then go to IDLE.
  - IDLE: wait for `start`.
  - ACQUIRE: `acq_en`=1.
  - DRAIN: wait until the read-modify-write (RMW) unit is empty.
  - DUMP: stream the bins.
- Reset entry is CLEAR, because RAM contents are undefined.
- `start` is honoured only in IDLE. In any other state it is ignored.
- When `start` is accepted: latch `n_samples`, zero `sample_cnt`, clear `overrun`.
  - If `n_samples`=0, go directly to DUMP.
  - Otherwise go to ACQUIRE.
- ACQUIRE:
  - Each `d_en` with a free slot is accepted and `sample_cnt` increments.
  - When `sample_cnt` reaches the latched count, go to DRAIN.
  - `d_en` outside ACQUIRE is ignored and is not counted.
- RMW unit: 3 cycles per sample (read issue, read data, write of sat(x+1)).
  - A one-entry pending slot holds a sample that arrives while the unit is busy.
  - A `d_en` that arrives while both the unit and the slot are occupied sets `overrun`. That sample is dropped and not counted.
  - Each write completes before the next read issues, so same-bin back-to-back updates need no forwarding.
- Saturation: a bin at all-ones stays at all-ones.
- DUMP:
  - Bins stream in ascending order, 0 to 2^WIDTH−1.
  - A handshake occurs on the cycle where `hist_valid && hist_ready`.
  - After the last handshake: pulse `done`, then go to CLEAR, then IDLE.
- `abort` in ACQUIRE, DRAIN or DUMP:
  - Go to CLEAR on the next edge; `acq_en` drops on that edge.
  - `hist_valid` deasserts, the in-flight RMW is discarded, and `done` is not pulsed.
  - `abort` in IDLE or CLEAR has no effect.
  - If `abort` and `start` are asserted together in IDLE, `start` wins.

## Timing
- Reset values of outputs:
  - `acq_en`, `done`, `overrun`, `hist_valid`, `hist_last` = 0.
  - `hist_addr`, `hist_data`, `code_min`, `code_max` = 0.
  - `busy` = 1, because the block is in CLEAR.
- CLEAR lasts exactly 2^WIDTH cycles.
- `acq_en` rises on the edge after `start` is accepted. It falls on the edge after the n-th accepted `d_en`.
- DRAIN ends at most 3 cycles after the pending slot empties.
- The first `hist_valid` asserts 2 cycles after entering DUMP (RAM read latency).
- While `hist_valid && !hist_ready`, `hist_addr`, `hist_data` and `hist_last` are held stable.
- After a handshake, the next beat can follow in the very next cycle, i.e. full throughput.
- `done` is asserted in the cycle after the last handshake. `busy` stays high through the final CLEAR.
- `hist_valid` never depends combinationally on `hist_ready`.

## Configuration
- Macro: `CODE_DENSITY_MINMAX_EN`.
- Defined:
  - `code_min` and `code_max` track the smallest and largest accepted code of the run.
  - Accepted `start` resets them to all-ones (`code_min`) and 0 (`code_max`).
  - They are updated on the cycle after each accepted sample and held after the run until the next `start`.
- Undefined: the tracking logic is removed and both outputs are constant 0.

## Test plan
- Reset, then wait 2^WIDTH cycles → `busy` falls and IDLE is reached; a dump after a 0-sample run returns all 1024 bins = 0 with `hist_last` only at addr 1023.
- `start` with `n_samples`=5, codes 3,3,7,1023,3 spaced 300 cycles → bin3=3, bin7=1, bin1023=1, all others 0; `done` pulses once; `acq_en` high for exactly the acquisition window.
- `d_en` on 3 consecutive cycles, codes 9,9,9 → first two accepted, third sets `overrun`; bin9=2.
- Bin saturation with CNT_WIDTH=2 and 5 samples of code 4 → bin4=3.
- `hist_ready` toggled randomly during DUMP → no beat is lost or duplicated and data stays stable while stalled; `abort` mid-DUMP at addr 500 → `hist_valid` low next cycle, no `done`, IDLE after 1024 clear cycles.
- With `CODE_DENSITY_MINMAX_EN`, codes 12,800,5 → `code_min`=5, `code_max`=800; without the macro, both read 0.
